operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand data width in bits.
REQ-002 Parameter NSRC, default 4, SHALL set the number of operand sources (2..16).
REQ-003 Parameter IMM_W, default 16, SHALL set the raw immediate width (1..WIDTH).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_vld  in  1  upstream request valid.
REQ-008 in_rdy  out  1  stage can accept a request.
REQ-009 sel  in  SW=max(1,$clog2(NSRC))  source index.
REQ-010 is_imm  in  1  select immediate instead of a source.
REQ-011 imm_sext  in  1  1 = sign-extend imm, 0 = zero-extend.
REQ-012 imm  in  IMM_W  raw immediate.
REQ-013 src_din  in  NSRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-014 src_vld  in  NSRC  per-source data-available flag.
REQ-015 out_vld  out  1  op1 holds a valid operand.
REQ-016 out_rdy  in  1  downstream accepts op1.
REQ-017 op1  out  WIDTH  registered operand.
REQ-018 stall_cnt  out  16  count of operand-unavailable stall cycles.

Function
REQ-019 opnd_ok SHALL be 1 when is_imm=1, sel>=NSRC, or src_vld[sel]=1; otherwise 0.
REQ-020 Operand value SHALL be: is_imm=1 -> imm extended to WIDTH per imm_sext; else sel<NSRC -> source sel; else 0.
REQ-021 A request SHALL be accepted on a rising edge where in_vld && in_rdy && opnd_ok; is_imm takes priority over sel.
REQ-022 Operand latency SHALL be exactly 1 cycle: out_vld and op1 update on the edge of acceptance.
REQ-023 An output transfer SHALL occur on an edge where out_vld && out_rdy.
REQ-024 While out_vld=1 and out_rdy=0, op1 and out_vld SHALL hold unchanged.
REQ-025 Upstream SHALL hold in_vld and all request fields stable until acceptance; requests with opnd_ok=0 are not accepted.
REQ-026 Simultaneous output transfer and acceptance SHALL replace op1 with the new operand, sustaining 1 operand/cycle.
REQ-027 Output transfer without acceptance SHALL clear out_vld (or advance the skid entry, REQ-035).
REQ-028 stall_cnt SHALL increment on every edge with in_vld && in_rdy && !opnd_ok, saturate at 16'hFFFF, and clear only on reset.
REQ-029 Operands SHALL leave in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-030 While rst=1: out_vld=0, op1=0, stall_cnt=0, skid entry empty, in_rdy=0.
REQ-031 The first cycle after rst deasserts SHALL have in_rdy=1.
REQ-032 Reset asserted mid-operation SHALL discard in-flight operands at the next edge without producing an output transfer.

Configuration
REQ-033 Macro OPERAND_STAGE_SKID_EN SHALL select the ready scheme.
REQ-034 Without OPERAND_STAGE_SKID_EN: single output register; in_rdy = !out_vld || out_rdy (combinational from out_rdy).
REQ-035 With OPERAND_STAGE_SKID_EN: a second skid entry is added; in_rdy SHALL be a register output equal to "skid empty"; an acceptance while out_vld && !out_rdy fills the skid; the skid moves into op1 on the next output transfer; no combinational out_rdy->in_rdy path.

Verification
REQ-036 Immediate: is_imm=1, imm=16'h8001, imm_sext=1 -> next cycle op1=32'hFFFF8001, out_vld=1; imm_sext=0 -> op1=32'h00008001.
REQ-037 Source select: src_din[2]=32'hDEADBEEF, src_vld=4'b1111, sel=2 -> op1=32'hDEADBEEF after 1 cycle; back-to-back sel=0,1,2,3 with out_rdy=1 -> 4 operands in 4 consecutive cycles.
REQ-038 Unavailable source: sel=1, src_vld[1]=0 for 5 cycles then 1 -> no acceptance for 5 cycles, stall_cnt=5, operand emitted on cycle 6.
REQ-039 Backpressure: out_rdy=0 for 3 cycles with 2 requests queued -> op1 holds first operand; without skid in_rdy=0; with skid second accepted then in_rdy=0; release -> both delivered in order.
REQ-040 Out-of-range/saturation/reset: NSRC=3, sel=3 -> op1=0 accepted immediately; forced 70000 stall cycles -> stall_cnt=16'hFFFF; rst pulse with out_vld=1 -> out_vld=0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/operand_stage.sv
// Operand select stage: registers an extended immediate or one of NSRC sources.
// Define OPERAND_STAGE_SKID_EN for a registered in_rdy with a second (skid) entry.
module operand_stage #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int IMM_W = 16,
  localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [SW-1:0]         sel,
  input  logic                  is_imm,
  input  logic                  imm_sext,
  input  logic [IMM_W-1:0]      imm,
  input  logic [NSRC*WIDTH-1:0] src_din,
  input  logic [NSRC-1:0]       src_vld,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [WIDTH-1:0]      op1,
  output logic [15:0]           stall_cnt
);

  logic [WIDTH-1:0] imm_ext_s;
  logic [WIDTH-1:0] src_val_s;
  logic             src_ok_s;
  logic [WIDTH-1:0] opnd_s;
  logic             opnd_ok_s;
  logic             acc_s;
  logic             xfer_s;
  logic             out_vld_n_s;
  logic [WIDTH-1:0] op1_n_s;
  logic [15:0]      stall_n_s;
  logic             out_vld_r;
  logic [WIDTH-1:0] op1_r;
  logic [15:0]      stall_r;
`ifdef OPERAND_STAGE_SKID_EN
  logic             skid_vld_n_s;
  logic [WIDTH-1:0] skid_n_s;
  logic             skid_vld_r;
  logic [WIDTH-1:0] skid_r;
  logic             rdy_r;
`endif

  // Operand lookup; an out-of-range index reads as zero and is always available.
  always_comb begin
    imm_ext_s            = {WIDTH{imm_sext & imm[IMM_W-1]}};
    imm_ext_s[IMM_W-1:0] = imm;
    src_val_s            = {WIDTH{1'b0}};
    src_ok_s             = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      src_val_s = (int'(sel) == k) ? src_din[k*WIDTH +: WIDTH] : src_val_s;
      src_ok_s  = (int'(sel) == k) ? src_vld[k] : src_ok_s;
    end
    opnd_s    = is_imm ? imm_ext_s : src_val_s;
    opnd_ok_s = is_imm | src_ok_s;
  end

`ifdef OPERAND_STAGE_SKID_EN
  assign in_rdy = rdy_r & ~rst;
`else
  assign in_rdy = ~rst & (~out_vld_r | out_rdy);
`endif

  // Next-state for the output register, skid entry and stall counter.
  always_comb begin
    acc_s       = in_vld & in_rdy & opnd_ok_s;
    xfer_s      = out_vld_r & out_rdy;
    out_vld_n_s = out_vld_r;
    op1_n_s     = op1_r;
`ifdef OPERAND_STAGE_SKID_EN
    skid_vld_n_s = skid_vld_r;
    skid_n_s     = skid_r;
    if (skid_vld_r) begin
      if (xfer_s) begin
        op1_n_s      = skid_r;
        skid_vld_n_s = 1'b0;
      end else begin
        op1_n_s = op1_r;
      end
    end else if (acc_s) begin
      // A blocked output register diverts the new operand into the skid entry.
      if (~out_vld_r | out_rdy) begin
        op1_n_s     = opnd_s;
        out_vld_n_s = 1'b1;
      end else begin
        skid_n_s     = opnd_s;
        skid_vld_n_s = 1'b1;
      end
    end else if (xfer_s) begin
      out_vld_n_s = 1'b0;
    end else begin
      out_vld_n_s = out_vld_r;
    end
`else
    if (acc_s) begin
      op1_n_s     = opnd_s;
      out_vld_n_s = 1'b1;
    end else if (xfer_s) begin
      out_vld_n_s = 1'b0;
    end else begin
      out_vld_n_s = out_vld_r;
    end
`endif
    if (in_vld & in_rdy & ~opnd_ok_s & (stall_r != 16'hFFFF)) begin
      stall_n_s = stall_r + 16'd1;
    end else begin
      stall_n_s = stall_r;
    end
  end

  // State registers; reset discards any held operand without a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      op1_r      <= {WIDTH{1'b0}};
      stall_r    <= 16'h0000;
`ifdef OPERAND_STAGE_SKID_EN
      skid_vld_r <= 1'b0;
      skid_r     <= {WIDTH{1'b0}};
      rdy_r      <= 1'b1;
`endif
    end else begin
      out_vld_r  <= out_vld_n_s;
      op1_r      <= op1_n_s;
      stall_r    <= stall_n_s;
`ifdef OPERAND_STAGE_SKID_EN
      skid_vld_r <= skid_vld_n_s;
      skid_r     <= skid_n_s;
      rdy_r      <= ~skid_vld_n_s;
`endif
    end
  end

  assign out_vld   = out_vld_r;
  assign op1       = op1_r;
  assign stall_cnt = stall_r;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed requests push expected operands,
// a negedge monitor pops and compares on every output transfer.
module tb_operand_stage;

  logic         clk;
  logic         rst;
  logic         in_vld;
  logic         in_rdy;
  logic [1:0]   sel;
  logic         is_imm;
  logic         imm_sext;
  logic [15:0]  imm;
  logic [127:0] src_din;
  logic [3:0]   src_vld;
  logic         out_vld;
  logic         out_rdy;
  logic [31:0]  op1;
  logic [15:0]  stall_cnt;

  logic         in_vld3;
  logic         in_rdy3;
  logic [1:0]   sel3;
  logic         is_imm3;
  logic [95:0]  src_din3;
  logic [2:0]   src_vld3;
  logic         out_vld3;
  logic         out_rdy3;
  logic [31:0]  op1_3;
  logic [15:0]  stall3;

  int           checks;
  int           failures;
  int           cyc;
  logic [31:0]  exp_q[$];
  int           xfer_cyc[$];
  logic [31:0]  exp_v;

  operand_stage dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .sel(sel),
    .is_imm(is_imm), .imm_sext(imm_sext), .imm(imm), .src_din(src_din),
    .src_vld(src_vld), .out_vld(out_vld), .out_rdy(out_rdy), .op1(op1),
    .stall_cnt(stall_cnt)
  );

  operand_stage #(.WIDTH(32), .NSRC(3), .IMM_W(16)) dut3 (
    .clk(clk), .rst(rst), .in_vld(in_vld3), .in_rdy(in_rdy3), .sel(sel3),
    .is_imm(is_imm3), .imm_sext(imm_sext), .imm(imm), .src_din(src_din3),
    .src_vld(src_vld3), .out_vld(out_vld3), .out_rdy(out_rdy3), .op1(op1_3),
    .stall_cnt(stall3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected operand.
  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h expected=none", op1);
      end else begin
        exp_v = exp_q.pop_front();
        chk("sb_op1", op1, exp_v);
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic ii, input logic sx,
                      input logic [15:0] im, input logic [31:0] ev);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    sel = s; is_imm = ii; imm_sext = sx; imm = im; in_vld = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (in_rdy && (ii || src_vld[s])) begin
        exp_q.push_back(ev);
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_vld = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted sel=%0d", s);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; in_vld = 1'b0; sel = 2'd0; is_imm = 1'b0; imm_sext = 1'b0;
    imm = 16'h0000; out_rdy = 1'b1;
    src_din = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    src_vld = 4'b1111;
    in_vld3 = 1'b0; sel3 = 2'd0; is_imm3 = 1'b0; out_rdy3 = 1'b1;
    src_din3 = {32'h33333333, 32'h22222222, 32'h11111111};
    src_vld3 = 3'b111;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    @(posedge clk); #1;

    // Out-of-range select on the NSRC=3 instance
    is_imm3 = 1'b1; imm = 16'h00AA; imm_sext = 1'b0; in_vld3 = 1'b1;
    @(posedge clk); #1;
    chk("n3_imm_op1", op1_3, 32'h000000AA);
    is_imm3 = 1'b0; sel3 = 2'd3; src_vld3 = 3'b000;
    @(negedge clk);
    chk("n3_in_rdy", {31'd0, in_rdy3}, 32'd1);
    @(posedge clk); #1;
    in_vld3 = 1'b0;
    chk("n3_oor_op1", op1_3, 32'd0);
    chk("n3_oor_vld", {31'd0, out_vld3}, 32'd1);
    chk("n3_oor_stall", {16'd0, stall3}, 32'd0);

    // Immediates, sign- and zero-extended
    send(2'd0, 1'b1, 1'b1, 16'h8001, 32'hFFFF8001);
    chk("imm_sext_lat", op1, 32'hFFFF8001);
    chk("imm_sext_vld", {31'd0, out_vld}, 32'd1);
    send(2'd0, 1'b1, 1'b0, 16'h8001, 32'h00008001);
    chk("imm_zext_lat", op1, 32'h00008001);
    idle(2);

    // Source select and back-to-back throughput
    send(2'd2, 1'b0, 1'b0, 16'h0000, 32'hDEADBEEF);
    chk("src2_lat", op1, 32'hDEADBEEF);
    idle(2);
    send(2'd0, 1'b0, 1'b0, 16'h0000, 32'h11111111);
    send(2'd1, 1'b0, 1'b0, 16'h0000, 32'h22222222);
    send(2'd2, 1'b0, 1'b0, 16'h0000, 32'hDEADBEEF);
    send(2'd3, 1'b0, 1'b0, 16'h0000, 32'h44444444);
    idle(3);
    chk("b2b_span", xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[xfer_cyc.size()-4], 32'd3);

    // Unavailable source stalls for five cycles
    src_vld = 4'b1101; sel = 2'd1; is_imm = 1'b0; in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_no_out", {31'd0, out_vld}, 32'd0);
    end
    chk("stall_cnt5", {16'd0, stall_cnt}, 32'd5);
    src_vld = 4'b1111;
    send(2'd1, 1'b0, 1'b0, 16'h0000, 32'h22222222);
    chk("stall_then_out", op1, 32'h22222222);
    idle(2);

    // Backpressure with two requests
    out_rdy = 1'b0;
    send(2'd0, 1'b1, 1'b0, 16'h1234, 32'h00001234);
    is_imm = 1'b1; imm_sext = 1'b1; imm = 16'hF00F; in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
`ifdef OPERAND_STAGE_SKID_EN
      chk("bp_in_rdy", {31'd0, in_rdy}, (i == 0) ? 32'd1 : 32'd0);
      if (i == 0) exp_q.push_back(32'hFFFFF00F);
`else
      chk("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
`endif
      chk("bp_hold_op1", op1, 32'h00001234);
      chk("bp_hold_vld", {31'd0, out_vld}, 32'd1);
      @(posedge clk); #1;
`ifdef OPERAND_STAGE_SKID_EN
      if (i == 0) in_vld = 1'b0;
`endif
    end
    out_rdy = 1'b1;
`ifndef OPERAND_STAGE_SKID_EN
    send(2'd0, 1'b1, 1'b1, 16'hF00F, 32'hFFFFF00F);
`endif
    idle(4);
    chk("bp_drained", exp_q.size(), 32'd0);

    // Stall counter saturation
    is_imm = 1'b0; sel = 2'd3; src_vld = 4'b0000; in_vld = 1'b1;
    idle(65529);
    chk("stall_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
    idle(10);
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    in_vld = 1'b0; src_vld = 4'b1111;
    idle(1);

    // Reset while an operand is held
    out_rdy = 1'b0;
    send(2'd0, 1'b1, 1'b0, 16'h0F0F, 32'h00000F0F);
    chk("pre_rst_vld", {31'd0, out_vld}, 32'd1);
    exp_v = exp_q.pop_back();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_vld", {31'd0, out_vld}, 32'd0);
    chk("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("mid_rst_op1", op1, 32'd0);
    rst = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    idle(3);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
